// File: rtl/cla_seq_adder.sv
// Multi-cycle W*N-bit adder that reuses one W-bit carry-lookahead adder per chunk, LSB chunk first.
// Optional subtraction (sub port, B inversion) is enabled by defining CLA_SEQ_SUB_EN.

module carry_lookahead_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] s,
    output logic         c_out
);

    logic [W-1:0] g_s;
    logic [W-1:0] p_s;
    logic [W:0]   c_s;
    logic         prod_s;

    // Each carry is a flat sum of generate terms gated by the propagates above them.
    always_comb begin
        g_s    = a & b;
        p_s    = a ^ b;
        c_s    = {(W+1){1'b0}};
        c_s[0] = c_in;
        prod_s = 1'b0;
        for (int i = 0; i < W; i++) begin
            c_s[i+1] = g_s[i];
            prod_s   = p_s[i];
            for (int j = i - 1; j >= 0; j--) begin
                c_s[i+1] = c_s[i+1] | (prod_s & g_s[j]);
                prod_s   = prod_s & p_s[j];
            end
            c_s[i+1] = c_s[i+1] | (prod_s & c_in);
        end
        s     = p_s ^ c_s[W-1:0];
        c_out = c_s[W];
    end

endmodule

module cla_seq_adder #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W*N-1:0] a,
    input  logic [W*N-1:0] b,
    input  logic           c_in,
`ifdef CLA_SEQ_SUB_EN
    input  logic           sub,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W*N-1:0] s,
    output logic           c_out,
    output logic           ovf
);

    localparam int WN = W * N;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [WN-1:0] a_q, a_d;
    logic [WN-1:0] b_q, b_d;
    logic [WN-1:0] acc_q, acc_d;
    logic [WN-1:0] s_q, s_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          c_out_q, c_out_d;
    logic          ovf_q, ovf_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [WN-1:0] b_eff_s;
    logic          carry_init_s;
    logic [W-1:0]  add_a_s;
    logic [W-1:0]  add_b_s;
    logic [W-1:0]  add_sum_s;
    logic          add_co_s;

    // Effective B operand and initial carry at accept time.
    always_comb begin
`ifdef CLA_SEQ_SUB_EN
        if (sub) begin
            b_eff_s      = ~b;
            carry_init_s = 1'b1;
        end else begin
            b_eff_s      = b;
            carry_init_s = c_in;
        end
`else
        b_eff_s      = b;
        carry_init_s = c_in;
`endif
    end

    // Chunk selection for the shared adder.
    always_comb begin
        add_a_s = a_q[idx_q*W +: W];
        add_b_s = b_q[idx_q*W +: W];
    end

    carry_lookahead_adder #(.W(W)) u_cla (
        .a     (add_a_s),
        .b     (add_b_s),
        .c_in  (carry_q),
        .s     (add_sum_s),
        .c_out (add_co_s)
    );

    // Next-state logic; the visible sum is only updated when the last chunk completes.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        s_d         = s_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        c_out_d     = c_out_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b_eff_s;
                    carry_d    = carry_init_s;
                    idx_d      = {IW{1'b0}};
                    acc_d      = {WN{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            RUN: begin
                acc_d[idx_q*W +: W] = add_sum_s;
                carry_d             = add_co_s;
                if (idx_q == IDX_LAST) begin
                    s_d         = acc_d;
                    c_out_d     = add_co_s;
                    ovf_d       = (a_q[WN-1] == b_q[WN-1]) && (acc_d[WN-1] != a_q[WN-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= {WN{1'b0}};
            b_q         <= {WN{1'b0}};
            acc_q       <= {WN{1'b0}};
            s_q         <= {WN{1'b0}};
            idx_q       <= {IW{1'b0}};
            carry_q     <= 1'b0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            s_q         <= s_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule
